operand_stage: RTL and testbench
================================

// Module: operand_stage
// PURPOSE
//  Pipeline stage directly downstream of the register file. It drives the regfile read
//  addresses and consumes the registered read data one cycle later. It forwards in-flight
//  EX/MEM/WB results, including writes the regfile commits on the same edge it reads.
//  It detects load-use hazards and issues resolved operands to EX, inserting bubbles on stall.
// PARAMETERS
//  DATA_W  32  operand/result width
//  REG_AW  5   register address width; register 0 always reads as zero
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous reset, active-high
//  dec_valid    in   1       decode presents an instruction
//  dec_ra/rb    in   REG_AW  source register numbers
//  dec_rd       in   REG_AW  destination register
//  dec_wen      in   1       instruction writes dec_rd
//  dec_is_load  in   1       instruction is a load
//  stall_in     in   1       downstream (EX) cannot accept
//  rf_raddr0/1  out  REG_AW  regfile read addresses (= dec_ra/dec_rb, combinational)
//  rf_rdata0/1  in   DATA_W  regfile read data, valid the cycle after the address
//  rf_stall     out  1       = stall_out; regfile holds rdata when high
//  ex_wen,ex_is_load,ex_waddr,ex_wdata      in  EX-stage result (wdata invalid if ex_is_load)
//  mem_wen,mem_waddr,mem_wdata              in  MEM-stage result
//  wb_wen0/1,wb_waddr0/1,wb_wdata0/1        in  regfile write ports this cycle
//  op_valid     out  1       O-stage instruction issued to EX this cycle
//  op_a/op_b    out  DATA_W  resolved operands (0 when !op_valid)
//  op_rd,op_wen,op_is_load  out  passthrough of held instruction fields
//  stall_out    out  1       decode must hold its instruction
// BEHAVIOUR
//  - Two steps: R (address drive) and O (state regs o_vld, o_ra, o_rb, o_rd, o_wen, o_ld, o_held).
//  - R->O capture: on each clk edge with !stall_out, o_vld<=dec_valid and the fields are loaded.
//    o_held<=0. Latency: operands appear on op_* one cycle after the decode accept.
//  - late-WB regs: on every edge, capture wb_wen0/1, wb_waddr0/1, wb_wdata0/1 (lwb_*).
//    This covers writes the regfile committed on the same edge that captured rdata.
//  - Per-source resolution, highest priority first:
//    1. src==0 -> 0.
//    2. ex_wen && ex_waddr==src.
//    3. mem_wen && mem_waddr==src.
//    4. wb port0.
//    5. wb port1 (ignored if wb_waddr0==wb_waddr1 && wb_wen0).
//    6. lwb port0.
//    7. lwb port1 (same rule as item 5).
//    8. base, where base = o_held ? opq : rf_rdata.
//  - load_use = o_vld && ex_wen && ex_is_load && ex_waddr!=0 && (ex_waddr==o_ra || ex_waddr==o_rb).
//  - stall_out = o_vld && (stall_in || load_use). When stall_out is high:
//    - O fields are held and o_held<=1.
//    - opq_a/opq_b<=resolved values each cycle.
//  - op_valid = o_vld && !load_use. stall_in alone keeps op_* stable (EX re-samples).
//    A load-use bubble drives op_valid=0 and op_a/op_b=0.
//  - If !o_vld, stall_out=0 regardless of stall_in. Decode accepts into the empty O slot.
//  - Reset (async): o_vld=0, o_held=0, all O fields, opq and lwb regs =0.
//    Outputs go to op_valid=0, op_a/op_b/op_rd=0, op_wen=op_is_load=0, stall_out=0.
//    Reset mid-stall discards the held instruction; no replay.
//  - No state machine beyond {EMPTY, ISSUE, HELD}, encoded by o_vld/o_held:
//    - EMPTY->ISSUE on accept.
//    - ISSUE->HELD on stall_out.
//    - HELD->ISSUE/EMPTY when stall_out drops (next decode accepted or none).
// TESTING
//  1. r5=0x11 in regfile. Issue ra=5, rb=0, no producers -> next cycle op_valid=1, op_a=0x11, op_b=0.
//  2. WB writes r7=0xAA on the same edge the read of r7 is captured (rdata stale 0) -> op_a=0xAA via lwb.
//  3. EX r3=0x1, MEM r3=0x2, WB r3=0x3 all active; O reads r3 -> op_a=0x1 (EX wins).
//  4. Load r4 in EX, O reads r4 -> 1 cycle op_valid=0, stall_out=1.
//     Next cycle MEM forwards 0x55 -> op_a=0x55, op_valid=1.
//  5. stall_in=1 for 3 cycles, WB writes r9=0x99 in cycle 2, O reads r9 -> op_a tracks 0x99.
//     Held value is used after the stall releases.
//  6. WB both ports r6 (port0=0x10, port1=0x20) -> op_a=0x10.
//     Assert rst mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/operand_stage.sv
// Operand stage: drives regfile read addresses, captures the instruction into the
// O slot, resolves both source operands through EX/MEM/WB/late-WB forwarding, and
// holds the slot with a bubble on load-use or downstream stall.
//
// Handshake: decode is accepted on a rising edge whenever stall_out is low;
// stall_out high means decode must present the same instruction again. EX takes
// op_* on every edge where op_valid is high and stall_in is low. While stall_in is
// high, op_* stays stable so that EX can sample it again.
module operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_ra,
    input  logic [REG_AW-1:0] dec_rb,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_wen,
    input  logic              dec_is_load,
    input  logic              stall_in,
    output logic [REG_AW-1:0] rf_raddr0,
    output logic [REG_AW-1:0] rf_raddr1,
    input  logic [DATA_W-1:0] rf_rdata0,
    input  logic [DATA_W-1:0] rf_rdata1,
    output logic              rf_stall,
    input  logic              ex_wen,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_waddr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              mem_wen,
    input  logic [REG_AW-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              wb_wen0,
    input  logic [REG_AW-1:0] wb_waddr0,
    input  logic [DATA_W-1:0] wb_wdata0,
    input  logic              wb_wen1,
    input  logic [REG_AW-1:0] wb_waddr1,
    input  logic [DATA_W-1:0] wb_wdata1,
    output logic              op_valid,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [REG_AW-1:0] op_rd,
    output logic              op_wen,
    output logic              op_is_load,
    output logic              stall_out,
    output logic [1:0]        dbg_state
);

    // Slot state is carried by o_vld/o_held; the enum names it for debug.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ISSUE = 2'd1,
        HELD  = 2'd2
    } state_t;

    logic              o_vld, o_held, o_wen, o_ld;
    logic [REG_AW-1:0] o_ra, o_rb, o_rd;
    logic [DATA_W-1:0] opq_a, opq_b;

    logic              lwb_wen0, lwb_wen1;
    logic [REG_AW-1:0] lwb_waddr0, lwb_waddr1;
    logic [DATA_W-1:0] lwb_wdata0, lwb_wdata1;

    logic              nxt_vld, nxt_held, nxt_wen, nxt_ld;
    logic [REG_AW-1:0] nxt_ra, nxt_rb, nxt_rd;
    logic [DATA_W-1:0] nxt_opq_a, nxt_opq_b;

    logic              load_use;
    logic [DATA_W-1:0] res_a, res_b;
    state_t            state;

    // Forwarding priority: r0, EX, MEM, WB0, WB1, late WB0, late WB1, then base.
    // Port 1 loses to port 0 when both write the same register.
    function automatic logic [DATA_W-1:0] resolve(input logic [REG_AW-1:0] src,
                                                  input logic [DATA_W-1:0] base);
        logic [DATA_W-1:0] r;
        if (src == '0)                                   r = '0;
        else if (ex_wen && ex_waddr == src)              r = ex_wdata;
        else if (mem_wen && mem_waddr == src)            r = mem_wdata;
        else if (wb_wen0 && wb_waddr0 == src)            r = wb_wdata0;
        else if (wb_wen1 && wb_waddr1 == src &&
                 !(wb_wen0 && wb_waddr0 == wb_waddr1))   r = wb_wdata1;
        else if (lwb_wen0 && lwb_waddr0 == src)          r = lwb_wdata0;
        else if (lwb_wen1 && lwb_waddr1 == src &&
                 !(lwb_wen0 && lwb_waddr0 == lwb_waddr1)) r = lwb_wdata1;
        else                                             r = base;
        return r;
    endfunction

    assign rf_raddr0 = dec_ra;
    assign rf_raddr1 = dec_rb;

    // Hazard detection, operand resolution and issue outputs.
    always_comb begin
        load_use  = o_vld && ex_wen && ex_is_load && (ex_waddr != '0) &&
                    (ex_waddr == o_ra || ex_waddr == o_rb);
        stall_out = o_vld && (stall_in || load_use);
        rf_stall  = stall_out;
        res_a     = resolve(o_ra, o_held ? opq_a : rf_rdata0);
        res_b     = resolve(o_rb, o_held ? opq_b : rf_rdata1);
        op_valid  = o_vld && !load_use;
        op_a      = op_valid ? res_a : '0;
        op_b      = op_valid ? res_b : '0;
        op_rd     = o_rd;
        op_wen    = o_wen;
        op_is_load = o_ld;
        if (!o_vld)      state = EMPTY;
        else if (o_held) state = HELD;
        else             state = ISSUE;
        dbg_state = state;
    end

    // Next slot contents: accept from decode, or hold and snapshot the operands.
    always_comb begin
        nxt_vld   = dec_valid;
        nxt_held  = 1'b0;
        nxt_ra    = dec_ra;
        nxt_rb    = dec_rb;
        nxt_rd    = dec_rd;
        nxt_wen   = dec_wen;
        nxt_ld    = dec_is_load;
        nxt_opq_a = opq_a;
        nxt_opq_b = opq_b;
        if (stall_out) begin
            nxt_vld   = o_vld;
            nxt_held  = 1'b1;
            nxt_ra    = o_ra;
            nxt_rb    = o_rb;
            nxt_rd    = o_rd;
            nxt_wen   = o_wen;
            nxt_ld    = o_ld;
            nxt_opq_a = res_a;
            nxt_opq_b = res_b;
        end
    end

    // O slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_vld  <= 1'b0;
            o_held <= 1'b0;
            o_ra   <= '0;
            o_rb   <= '0;
            o_rd   <= '0;
            o_wen  <= 1'b0;
            o_ld   <= 1'b0;
            opq_a  <= '0;
            opq_b  <= '0;
        end else begin
            o_vld  <= nxt_vld;
            o_held <= nxt_held;
            o_ra   <= nxt_ra;
            o_rb   <= nxt_rb;
            o_rd   <= nxt_rd;
            o_wen  <= nxt_wen;
            o_ld   <= nxt_ld;
            opq_a  <= nxt_opq_a;
            opq_b  <= nxt_opq_b;
        end
    end

    // Late-WB copy: writes the regfile committed on the edge that captured rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lwb_wen0   <= 1'b0;
            lwb_wen1   <= 1'b0;
            lwb_waddr0 <= '0;
            lwb_waddr1 <= '0;
            lwb_wdata0 <= '0;
            lwb_wdata1 <= '0;
        end else begin
            lwb_wen0   <= wb_wen0;
            lwb_wen1   <= wb_wen1;
            lwb_waddr0 <= wb_waddr0;
            lwb_waddr1 <= wb_waddr1;
            lwb_wdata0 <= wb_wdata0;
            lwb_wdata1 <= wb_wdata1;
        end
    end

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: forwarding priority, late-WB, load-use, stall hold, reset.
module tb_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, dec_wen, dec_is_load, stall_in;
    logic [4:0]  dec_ra, dec_rb, dec_rd;
    logic [4:0]  rf_raddr0, rf_raddr1;
    logic [31:0] rf_rdata0, rf_rdata1;
    logic        rf_stall;
    logic        ex_wen, ex_is_load, mem_wen, wb_wen0, wb_wen1;
    logic [4:0]  ex_waddr, mem_waddr, wb_waddr0, wb_waddr1;
    logic [31:0] ex_wdata, mem_wdata, wb_wdata0, wb_wdata1;
    logic        op_valid, op_wen, op_is_load, stall_out;
    logic [31:0] op_a, op_b;
    logic [4:0]  op_rd;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    operand_stage dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ra(dec_ra), .dec_rb(dec_rb), .dec_rd(dec_rd),
        .dec_wen(dec_wen), .dec_is_load(dec_is_load), .stall_in(stall_in),
        .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1),
        .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1), .rf_stall(rf_stall),
        .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .wb_wen0(wb_wen0), .wb_waddr0(wb_waddr0), .wb_wdata0(wb_wdata0),
        .wb_wen1(wb_wen1), .wb_waddr1(wb_waddr1), .wb_wdata1(wb_wdata1),
        .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_rd(op_rd),
        .op_wen(op_wen), .op_is_load(op_is_load), .stall_out(stall_out),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle on current inputs before sampling.
    task automatic settle();
        #2;
    endtask

    task automatic clear_fwd();
        ex_wen = 0; ex_is_load = 0; ex_waddr = 0; ex_wdata = 0;
        mem_wen = 0; mem_waddr = 0; mem_wdata = 0;
        wb_wen0 = 0; wb_waddr0 = 0; wb_wdata0 = 0;
        wb_wen1 = 0; wb_waddr1 = 0; wb_wdata1 = 0;
    endtask

    task automatic issue(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd);
        dec_valid = 1; dec_ra = ra; dec_rb = rb; dec_rd = rd; dec_wen = 1; dec_is_load = 0;
    endtask

    initial begin
        rst = 1; stall_in = 0;
        dec_valid = 0; dec_ra = 0; dec_rb = 0; dec_rd = 0; dec_wen = 0; dec_is_load = 0;
        rf_rdata0 = 0; rf_rdata1 = 0;
        clear_fwd();
        step(); step();
        chk("reset_op_valid", {31'b0, op_valid}, 32'h0);
        chk("reset_stall_out", {31'b0, stall_out}, 32'h0);
        chk("reset_state", {30'b0, dbg_state}, 32'h0);
        rst = 0;
        step();

        // 1: plain regfile read; EX load to r0 must neither forward nor stall.
        issue(5'd5, 5'd0, 5'd12);
        settle();
        chk("raddr0", {27'b0, rf_raddr0}, 32'd5);
        step();
        dec_valid = 0; rf_rdata0 = 32'h11; rf_rdata1 = 32'hDEAD;
        ex_wen = 1; ex_is_load = 1; ex_waddr = 0; ex_wdata = 32'h77;
        settle();
        chk("t1_op_valid", {31'b0, op_valid}, 32'h1);
        chk("t1_op_a", op_a, 32'h11);
        chk("t1_op_b_r0", op_b, 32'h0);
        chk("t1_op_rd", {27'b0, op_rd}, 32'd12);
        chk("t1_op_wen", {31'b0, op_wen}, 32'h1);
        chk("t1_no_stall_r0", {31'b0, stall_out}, 32'h0);
        chk("t1_state_issue", {30'b0, dbg_state}, 32'h1);
        clear_fwd();

        // 2: WB writes r7 on the capture edge; rdata stale; late-WB supplies value.
        issue(5'd7, 5'd0, 5'd1);
        wb_wen0 = 1; wb_waddr0 = 7; wb_wdata0 = 32'hAA;
        step();
        dec_valid = 0; clear_fwd(); rf_rdata0 = 32'h0;
        settle();
        chk("t2_lwb_op_a", op_a, 32'hAA);

        // 3: EX > MEM > WB > regfile.
        issue(5'd3, 5'd0, 5'd1);
        step();
        dec_valid = 0; rf_rdata0 = 32'h44;
        ex_wen = 1; ex_waddr = 3; ex_wdata = 32'h1;
        mem_wen = 1; mem_waddr = 3; mem_wdata = 32'h2;
        wb_wen0 = 1; wb_waddr0 = 3; wb_wdata0 = 32'h3;
        settle();
        chk("t3_ex_wins", op_a, 32'h1);
        ex_wen = 0; settle();
        chk("t3_mem_wins", op_a, 32'h2);
        mem_wen = 0; settle();
        chk("t3_wb_wins", op_a, 32'h3);
        wb_wen0 = 0; settle();
        chk("t3_rf_base", op_a, 32'h44);
        clear_fwd();

        // 4: load-use bubble, then MEM forwards the loaded value.
        issue(5'd4, 5'd0, 5'd2);
        step();
        dec_valid = 0; rf_rdata0 = 32'h0;
        ex_wen = 1; ex_is_load = 1; ex_waddr = 4; ex_wdata = 32'hBAD;
        settle();
        chk("t4_bubble_valid", {31'b0, op_valid}, 32'h0);
        chk("t4_bubble_op_a", op_a, 32'h0);
        chk("t4_stall_out", {31'b0, stall_out}, 32'h1);
        chk("t4_rf_stall", {31'b0, rf_stall}, 32'h1);
        step();
        clear_fwd();
        mem_wen = 1; mem_waddr = 4; mem_wdata = 32'h55;
        settle();
        chk("t4_mem_fwd", op_a, 32'h55);
        chk("t4_valid_after", {31'b0, op_valid}, 32'h1);
        chk("t4_stall_drop", {31'b0, stall_out}, 32'h0);
        chk("t4_state_held", {30'b0, dbg_state}, 32'h2);
        step();
        clear_fwd();
        settle();
        chk("t4_empty", {31'b0, op_valid}, 32'h0);
        chk("t4_state_empty", {30'b0, dbg_state}, 32'h0);

        // 5: stall_in for 3 cycles, WB r9 in cycle 2; held value survives release.
        issue(5'd9, 5'd0, 5'd3);
        step();
        dec_valid = 0; rf_rdata0 = 32'h0; stall_in = 1;
        settle();
        chk("t5_c1_op_a", op_a, 32'h0);
        chk("t5_c1_stall", {31'b0, stall_out}, 32'h1);
        step();
        wb_wen0 = 1; wb_waddr0 = 9; wb_wdata0 = 32'h99;
        settle();
        chk("t5_c2_op_a", op_a, 32'h99);
        step();
        clear_fwd();
        settle();
        chk("t5_c3_op_a", op_a, 32'h99);
        step();
        stall_in = 0;
        settle();
        chk("t5_release_op_a", op_a, 32'h99);
        chk("t5_release_valid", {31'b0, op_valid}, 32'h1);
        step();

        // 6: WB dual write to r6 -> port0 wins; port1 alone forwards; reset mid-stall.
        issue(5'd6, 5'd6, 5'd4);
        step();
        dec_valid = 0; rf_rdata0 = 32'h0; rf_rdata1 = 32'h0;
        wb_wen0 = 1; wb_waddr0 = 6; wb_wdata0 = 32'h10;
        wb_wen1 = 1; wb_waddr1 = 6; wb_wdata1 = 32'h20;
        settle();
        chk("t6_port0_wins", op_a, 32'h10);
        wb_wen0 = 0; settle();
        chk("t6_port1_alone", op_b, 32'h20);
        clear_fwd();
        stall_in = 1;
        step();
        settle();
        chk("t6_stalled", {31'b0, stall_out}, 32'h1);
        rst = 1;
        #1;
        chk("t6_rst_valid", {31'b0, op_valid}, 32'h0);
        chk("t6_rst_op_a", op_a, 32'h0);
        chk("t6_rst_op_rd", {27'b0, op_rd}, 32'h0);
        chk("t6_rst_stall", {31'b0, stall_out}, 32'h0);
        chk("t6_rst_wen", {31'b0, op_wen}, 32'h0);
        step();
        rst = 0; stall_in = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
